uart_rx_core: RTL and testbench

Synthesizable UART receiver, the DUT-side stage fed directly by the testbench UART model's serial tx line. It oversamples the line at 16x, deserializes LSB-first frames with 5..9 data bits, optional parity and 1..2 stop bits, and presents each frame on a valid/ready output with parity, frame, noise and overrun status. Downstream logic (APB/AHB UART register block, RX FIFO) consumes the output.

---
 rtl/uart_rx_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver.
//
// It deserializes LSB-first frames with 5..9 data bits, optional parity
// (even, odd, stick-0 or stick-1) and 1..2 stop bits. Each bit is the
// majority vote of the samples at oversample counts 7, 8 and 9.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_en             receiver enable; low forces IDLE and drops a partial frame
//   baud_div          clk cycles per 1/16 bit, minus 1
//   data_bits         data bit count (clamped to 5..9)
//   stop_bits         stop bit count (0 -> 1, 3 -> 2)
//   parity_en         a parity bit follows the data bits
//   parity_mode       0 even, 1 odd, 2 stick-0, 3 stick-1
//   uart_rx           asynchronous serial input, idle high
//   rx_data           received data, right-aligned, unused upper bits 0
//   rx_valid, rx_ready  output handshake (see below)
//   parity_err, frame_err, noise_err  status held with rx_data
//   overrun_err       1-clk pulse when a completed frame was discarded
//   busy              FSM is not in IDLE
//
// Handshake: rx_data and the three held error flags are valid while
// rx_valid is high and stay stable until the cycle in which
// rx_valid && rx_ready, which is the transfer. rx_valid falls on the next
// clock unless a new frame is loaded in that same cycle. A frame that
// completes while rx_valid is high and rx_ready is low is discarded, and
// overrun_err pulses instead.
module uart_rx_core #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       data_bits,
    input  logic [1:0]       stop_bits,
    input  logic             parity_en,
    input  logic [1:0]       parity_mode,
    input  logic             uart_rx,
    output logic [8:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             noise_err,
    output logic             overrun_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;

    logic [DIV_W-1:0] cfg_div_q;
    logic [3:0]       cfg_last_q;     // index of the last data bit (4..8)
    logic             cfg_stop2_q;
    logic             cfg_par_en_q;
    logic [1:0]       cfg_mode_q;

    logic [DIV_W-1:0] tick_cnt_q;
    logic [3:0]       samp_cnt_q;
    logic             s7_q, s8_q;
    logic [3:0]       bit_cnt_q;
    logic [8:0]       shift_q;
    logic             pe_q, fe_q, ne_q;

    logic tick, bit_sample, voted, disagree, exp_par, frame_done;

    // Synchronizer; resets to the idle level so reset release is not a start edge.
    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rx_prev_q <= rx_s;
        end
    end

    // Configuration is captured continuously in IDLE and frozen for the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_div_q    <= '0;
            cfg_last_q   <= 4'd7;
            cfg_stop2_q  <= 1'b0;
            cfg_par_en_q <= 1'b0;
            cfg_mode_q   <= 2'd0;
        end else if (state_q == S_IDLE) begin
            cfg_div_q    <= baud_div;
            if (data_bits < 4'd5) begin
                cfg_last_q <= 4'd4;
            end else if (data_bits > 4'd9) begin
                cfg_last_q <= 4'd8;
            end else begin
                cfg_last_q <= data_bits - 4'd1;
            end
            cfg_stop2_q  <= stop_bits[1];   // 2 and 3 both mean two stop bits
            cfg_par_en_q <= parity_en;
            cfg_mode_q   <= parity_mode;
        end
    end

    assign tick       = (state_q != S_IDLE) && (tick_cnt_q == '0);
    assign bit_sample = tick && (samp_cnt_q == 4'd9);
    assign voted      = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign disagree   = !((s7_q == s8_q) && (s8_q == rx_s));
    assign busy       = (state_q != S_IDLE);

    // Unused upper bits of shift_q are zero, so the reductions see only data.
    always_comb begin
        exp_par = 1'b0;
        case (cfg_mode_q)
            2'd0:    exp_par = ^shift_q;
            2'd1:    exp_par = ~^shift_q;
            2'd2:    exp_par = 1'b0;
            default: exp_par = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        if (!rx_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s) state_d = S_START;
                end
                S_START: begin
                    if (bit_sample) state_d = voted ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (bit_sample && (bit_cnt_q == cfg_last_q)) begin
                        state_d = cfg_par_en_q ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (bit_sample) state_d = S_STOP;
                end
                S_STOP: begin
                    // Leave mid-stop-bit so a start edge right after the stop bit is seen.
                    if (bit_sample && (bit_cnt_q[0] == cfg_stop2_q)) begin
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Bit timing and frame accumulation; everything is held cleared in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            samp_cnt_q <= 4'd0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ne_q       <= 1'b0;
        end else if (state_q == S_IDLE) begin
            tick_cnt_q <= baud_div;
            samp_cnt_q <= 4'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ne_q       <= 1'b0;
        end else begin
            if (tick) begin
                tick_cnt_q <= cfg_div_q;
                samp_cnt_q <= samp_cnt_q + 4'd1;
                if (samp_cnt_q == 4'd7) s7_q <= rx_s;
                if (samp_cnt_q == 4'd8) s8_q <= rx_s;
            end else begin
                tick_cnt_q <= tick_cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
            end
            if (bit_sample) begin
                ne_q <= ne_q | disagree;
                case (state_q)
                    S_DATA: begin
                        shift_q[bit_cnt_q] <= voted;
                        bit_cnt_q <= (bit_cnt_q == cfg_last_q) ? 4'd0 : bit_cnt_q + 4'd1;
                    end
                    S_PARITY: pe_q <= voted ^ exp_par;
                    S_STOP: begin
                        fe_q      <= fe_q | ~voted;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register. The final stop sample is folded in directly
    // because it has not reached fe_q/ne_q yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= 9'd0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            noise_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_q;
                    rx_valid   <= 1'b1;
                    parity_err <= pe_q;
                    frame_err  <= fe_q | ~voted;
                    noise_err  <= ne_q | disagree;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives serial frames into uart_rx_core and checks every
// accepted frame against an expected queue. The expected entries come from
// the frame format rules: clamped bit counts, parity and stop-bit checks.
// Directed literal checks pin the known vectors.
module tb_uart_rx_core;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rx_en;
    logic [DIV_W-1:0] baud_div;
    logic [3:0]       data_bits;
    logic [1:0]       stop_bits;
    logic             parity_en;
    logic [1:0]       parity_mode;
    logic             uart_rx;
    logic [8:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             parity_err;
    logic             frame_err;
    logic             noise_err;
    logic             overrun_err;
    logic             busy;

    uart_rx_core #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_div(baud_div),
        .data_bits(data_bits), .stop_bits(stop_bits), .parity_en(parity_en),
        .parity_mode(parity_mode), .uart_rx(uart_rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .noise_err(noise_err), .overrun_err(overrun_err),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ovr_cnt = 0;
    bit          auto_ready = 1'b0;
    logic [11:0] exp_q[$];       // {data[8:0], parity_err, frame_err, noise_err}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int clamp_bits(input logic [3:0] raw);
        if (raw < 4'd5) return 5;
        if (raw > 4'd9) return 9;
        return int'(raw);
    endfunction

    function automatic int clamp_stop(input logic [1:0] raw);
        return (raw >= 2'd2) ? 2 : 1;
    endfunction

    function automatic logic par_expected(input logic [1:0] mode, input logic [8:0] d);
        case (mode)
            2'd0:    return ^d;
            2'd1:    return ~^d;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_level(input logic v, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            uart_rx = v;
            @(negedge clk);
        end
    endtask

    // Line bit index 0 is the start bit. g_bit selects one line bit in which the
    // level is inverted for g_len cycles starting g_from cycles into that bit.
    task automatic send_frame(input logic [8:0] d, input int nb, input bit pen, input bit pbit,
                              input logic [1:0] spat, input int ns, input int bc,
                              input int g_bit, input int g_from, input int g_len);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        for (int i = 0; i < ns; i++) bits.push_back(spat[i]);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < bc; c++) begin
                if (b == g_bit && c >= g_from && c < g_from + g_len) uart_rx = ~bits[b];
                else uart_rx = bits[b];
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!rx_valid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    endtask

    task automatic accept_one();
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic chk_frame(input string name, input logic [8:0] d, input logic pe,
                             input logic fe, input logic ne);
        chk({name, "_data"}, 32'(rx_data), 32'(d));
        chk({name, "_perr"}, 32'(parity_err), 32'(pe));
        chk({name, "_ferr"}, 32'(frame_err), 32'(fe));
        chk({name, "_nerr"}, 32'(noise_err), 32'(ne));
    endtask

    // ---------------- consumer ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_ready) rx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n) begin
            if (overrun_err) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", 32'({rx_data, parity_err, frame_err, noise_err}), 32'(e));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (120000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [3:0] rb;
        logic [1:0] rs, pm, spat;
        bit         pen, pbit, pe, fe;
        logic [8:0] d, dm;
        int         nb, ns, gap, ovr_before;

        rst_n = 1'b0; rx_en = 1'b1; baud_div = 16'd26; data_bits = 4'd8; stop_bits = 2'd1;
        parity_en = 1'b0; parity_mode = 2'd0; uart_rx = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ovr", 32'(overrun_err), 32'd0);
        chk_frame("reset", 9'h000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 at baud_div 26
        exp_q.push_back({9'h0A5, 3'b000});
        send_frame(9'h0A5, 8, 0, 0, 2'b11, 1, 432, -1, 0, 0);
        wait_valid("a5", 200);
        chk_frame("a5", 9'h0A5, 1'b0, 1'b0, 1'b0);
        accept_one();
        chk("a5_drop", 32'(rx_valid), 32'd0);
        @(negedge clk);

        // about 1.9% slow and fast line
        exp_q.push_back({9'h03A, 3'b000});
        send_frame(9'h03A, 8, 0, 0, 2'b11, 1, 440, -1, 0, 0);
        wait_valid("slow", 200);
        accept_one(); @(negedge clk);
        exp_q.push_back({9'h0C5, 3'b000});
        send_frame(9'h0C5, 8, 0, 0, 2'b11, 1, 424, -1, 0, 0);
        wait_valid("fast", 200);
        accept_one(); @(negedge clk);

        // parity, bit time 64 cycles
        baud_div = 16'd3;
        parity_en = 1'b1; parity_mode = 2'd0;
        drive_level(1'b1, 8);
        exp_q.push_back({9'h03C, 2'b00, 1'b0});
        send_frame(9'h03C, 8, 1, 0, 2'b11, 1, 64, -1, 0, 0);
        wait_valid("even_ok", 64);
        chk_frame("even_ok", 9'h03C, 1'b0, 1'b0, 1'b0);
        accept_one(); @(negedge clk);
        exp_q.push_back({9'h03C, 3'b100});
        send_frame(9'h03C, 8, 1, 1, 2'b11, 1, 64, -1, 0, 0);
        wait_valid("even_bad", 64);
        chk_frame("even_bad", 9'h03C, 1'b1, 1'b0, 1'b0);
        accept_one(); @(negedge clk);
        parity_mode = 2'd3;
        exp_q.push_back({9'h03C, 3'b000});
        send_frame(9'h03C, 8, 1, 1, 2'b11, 1, 64, -1, 0, 0);
        wait_valid("stick1", 64);
        chk_frame("stick1", 9'h03C, 1'b0, 1'b0, 1'b0);
        accept_one(); @(negedge clk);

        // 9 data bits, 2 stop bits
        parity_en = 1'b0; data_bits = 4'd9; stop_bits = 2'd2;
        exp_q.push_back({9'h1FF, 3'b010});
        send_frame(9'h1FF, 9, 0, 0, 2'b01, 2, 64, -1, 0, 0);
        wait_valid("stop01", 64);
        chk_frame("stop01", 9'h1FF, 1'b0, 1'b1, 1'b0);
        accept_one(); @(negedge clk);
        exp_q.push_back({9'h1FF, 3'b000});
        send_frame(9'h1FF, 9, 0, 0, 2'b11, 2, 64, -1, 0, 0);
        wait_valid("stop11", 64);
        chk_frame("stop11", 9'h1FF, 1'b0, 1'b0, 1'b0);
        accept_one(); @(negedge clk);

        // idle glitch of bit/4 is a false start
        data_bits = 4'd8; stop_bits = 2'd1;
        drive_level(1'b1, 8);
        drive_level(1'b0, 16);
        drive_level(1'b1, 4);
        chk("glitch_busy", 32'(busy), 32'd1);
        drive_level(1'b1, 44);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_novalid", 32'(rx_valid), 32'd0);

        // glitch on sample 7 only, inside data bit 3 (line bit 4)
        exp_q.push_back({9'h0FF, 3'b001});
        send_frame(9'h0FF, 8, 0, 0, 2'b11, 1, 64, 4, 31, 3);
        wait_valid("noise", 64);
        chk_frame("noise", 9'h0FF, 1'b0, 1'b0, 1'b1);
        accept_one(); @(negedge clk);

        // break: one frame with frame_err, no repeat while the line stays low
        exp_q.push_back({9'h000, 3'b010});
        drive_level(1'b0, 640);
        wait_valid("break", 64);
        chk_frame("break", 9'h000, 1'b0, 1'b1, 1'b0);
        accept_one(); @(negedge clk);
        drive_level(1'b0, 128);
        chk("break_norepeat", 32'(rx_valid), 32'd0);
        chk("break_idle", 32'(busy), 32'd0);
        drive_level(1'b1, 64);

        // rx_en low mid-frame drops the partial frame
        drive_level(1'b0, 64);
        drive_level(1'b1, 64);
        drive_level(1'b0, 30);
        rx_en = 1'b0;
        drive_level(1'b0, 2);
        chk("en_off_idle", 32'(busy), 32'd0);
        drive_level(1'b1, 64);
        rx_en = 1'b1;
        drive_level(1'b1, 4);
        chk("en_off_novalid", 32'(rx_valid), 32'd0);

        // back-to-back frames while the consumer stalls
        ovr_before = ovr_cnt;
        exp_q.push_back({9'h011, 3'b000});
        send_frame(9'h011, 8, 0, 0, 2'b11, 1, 64, -1, 0, 0);
        send_frame(9'h022, 8, 0, 0, 2'b11, 1, 64, -1, 0, 0);
        drive_level(1'b1, 4);
        chk("overrun_pulses", 32'(ovr_cnt - ovr_before), 32'd1);
        chk("overrun_hold", 32'(rx_data), 32'h011);
        chk("overrun_valid", 32'(rx_valid), 32'd1);
        accept_one();
        chk("overrun_drop", 32'(rx_valid), 32'd0);
        @(negedge clk);

        // randomized frames, random consumer back-pressure
        auto_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rb   = 4'($urandom_range(0, 15));
            rs   = 2'($urandom_range(0, 3));
            pm   = 2'($urandom_range(0, 3));
            pen  = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            d    = 9'($urandom_range(0, 511));
            spat = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            data_bits = rb; stop_bits = rs; parity_en = pen; parity_mode = pm;
            nb = clamp_bits(rb);
            ns = clamp_stop(rs);
            dm = '0;
            for (int i = 0; i < nb; i++) dm[i] = d[i];
            pe = pen && (pbit != par_expected(pm, dm));
            fe = 1'b0;
            for (int i = 0; i < ns; i++) if (!spat[i]) fe = 1'b1;
            exp_q.push_back({dm, pe, fe, 1'b0});
            send_frame(dm, nb, pen, pbit, spat, ns, 64, -1, 0, 0);
            gap = $urandom_range(0, 12);
            if (!spat[ns-1]) gap += 4;
            drive_level(1'b1, gap);
        end
        drive_level(1'b1, 100);
        auto_ready = 1'b0;
        rx_ready = 1'b0;
        drive_level(1'b1, 2);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of a frame, with a frame pending
        data_bits = 4'd8; stop_bits = 2'd1; parity_en = 1'b0; parity_mode = 2'd0;
        drive_level(1'b1, 4);
        exp_q.push_back({9'h077, 3'b000});
        send_frame(9'h077, 8, 0, 0, 2'b11, 1, 64, -1, 0, 0);
        drive_level(1'b1, 8);
        drive_level(1'b0, 64);
        drive_level(1'b1, 64);
        drive_level(1'b0, 64);
        drive_level(1'b1, 64);
        drive_level(1'b0, 20);
        chk("pre_reset_valid", 32'(rx_valid), 32'd1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(rx_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk_frame("async", 9'h000, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_level(1'b1, 64);
        exp_q.push_back({9'h066, 3'b000});
        send_frame(9'h066, 8, 0, 0, 2'b11, 1, 64, -1, 0, 0);
        wait_valid("after_reset", 64);
        chk_frame("after_reset", 9'h066, 1'b0, 1'b0, 1'b0);
        accept_one(); @(negedge clk);

        // ---------------- final report ----------------
        chk("overrun_total", 32'(ovr_cnt), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
